// File: rtl/rv32i_mem_defs.sv
// rtl/rv32i_mem_defs.sv - shared FSM encodings, constants and address helpers
package rv32i_mem_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } dstate_t;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Offset is relative to BASE_ADDR; anything at or past 4*2^log2_words bytes misses the array.
  function automatic logic off_out_of_range(input logic [31:0] offs, input int log2_words);
    return (offs >> (log2_words + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/rv32i_dp_ram.sv
// rtl/rv32i_dp_ram.sv - dual-port word RAM, synchronous reads, byte-enabled writes on port b
module rv32i_dp_ram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en_a,
  input  logic [AW-1:0] addr_a,
  output logic [31:0]   q_a,
  input  logic          en_b,
  input  logic [3:0]    we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [31:0]   wdata_b,
  output logic [31:0]   q_b
);

  logic [31:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_b[i]) mem[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
    end
  end

  // Only the read registers reset; array contents survive reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      if (en_a) q_a <= mem[addr_a];
      if (en_b) q_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/rv32i_mem_responder.sv
// rtl/rv32i_mem_responder.sv - instruction/data memory responder with read wait states
module rv32i_mem_responder
  import rv32i_mem_defs::*;
#(
  parameter int          MEM_LOG2_WORDS = 12,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          RD_WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] iaddress,
  input  logic        iread,
  output logic [31:0] ireaddata,
  input  logic [31:0] daddress,
  input  logic        dwrite,
  input  logic [31:0] dwritedata,
  input  logic [3:0]  dbyteenable,
  input  logic        dread,
  output logic [31:0] dreaddata,
  output logic        dwaitrequest,
  input  logic        err_clr,
  output logic        bus_error
);

  localparam int         AW        = MEM_LOG2_WORDS;
  localparam logic [3:0] WAIT_LOAD = 4'(RD_WAIT_STATES);

  dstate_t       state, state_nx;
  logic [3:0]    cnt;
  logic [AW-1:0] rd_idx;
  logic          rd_oor;
  logic          i_oor_q;
  logic [31:0]   i_off, d_off;
  logic [AW-1:0] i_idx, d_idx;
  logic          i_bad, d_bad;
  logic          wr_ok, rd_issue, err_set;
  logic [31:0]   q_a, q_b;

  assign i_off = iaddress - BASE_ADDR;
  assign d_off = daddress - BASE_ADDR;
  assign i_idx = AW'(i_off >> 2);
  assign d_idx = AW'(d_off >> 2);
  assign i_bad = off_out_of_range(i_off, AW);
  assign d_bad = off_out_of_range(d_off, AW);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      rd_idx <= '0;
      rd_oor <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && dread) begin
        cnt    <= WAIT_LOAD;
        rd_idx <= d_idx;
        rd_oor <= d_bad;
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (dread) state_nx = ST_WAIT;
      ST_WAIT: begin
        if (!dread)            state_nx = ST_IDLE;
        else if (cnt == 4'd0)  state_nx = ST_DATA;
      end
      ST_DATA: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Writes are only accepted in IDLE with no competing read; any other write is an error.
  always_comb begin
    dwaitrequest = 1'b0;
    rd_issue     = 1'b0;
    wr_ok        = 1'b0;
    err_set      = 1'b0;
    case (state)
      ST_IDLE: begin
        dwaitrequest = dread;
        wr_ok        = dwrite && !dread && !d_bad;
        err_set      = (dwrite && (dread || d_bad)) || (dread && d_bad);
      end
      ST_WAIT: begin
        dwaitrequest = 1'b1;
        rd_issue     = dread && (cnt == 4'd0);
        err_set      = dwrite;
      end
      ST_DATA: err_set = dwrite;
      default: err_set = 1'b0;
    endcase
    if (iread && i_bad) err_set = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_oor_q   <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      if (iread) i_oor_q <= i_bad;
      if (err_set)      bus_error <= 1'b1;
      else if (err_clr) bus_error <= 1'b0;
    end
  end

  assign ireaddata = i_oor_q ? NOP_INSN : q_a;
  assign dreaddata = (state == ST_DATA && !rd_oor) ? q_b : 32'd0;

  rv32i_dp_ram #(.AW(AW)) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .en_a    (iread),
    .addr_a  (i_idx),
    .q_a     (q_a),
    .en_b    (rd_issue),
    .we_b    (wr_ok ? dbyteenable : 4'b0000),
    .addr_b  (wr_ok ? d_idx : rd_idx),
    .wdata_b (dwritedata),
    .q_b     (q_b)
  );

endmodule

// File: tb/tb_rv32i_mem_responder.sv
// tb/tb_rv32i_mem_responder.sv - directed scoreboard bench for rv32i_mem_responder
module tb_rv32i_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] iaddress [2];
  logic [31:0] daddress [2];
  logic [31:0] dwritedata [2];
  logic        iread [2];
  logic        dwrite [2];
  logic        dread [2];
  logic        err_clr [2];
  logic [3:0]  dbyteenable [2];
  logic [31:0] ireaddata0, ireaddata1, dreaddata0, dreaddata1;
  logic        dwaitrequest0, dwaitrequest1, bus_error0, bus_error1;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  rv32i_mem_responder #(.MEM_LOG2_WORDS(12), .BASE_ADDR(32'h0), .RD_WAIT_STATES(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .iaddress(iaddress[0]), .iread(iread[0]), .ireaddata(ireaddata0),
    .daddress(daddress[0]), .dwrite(dwrite[0]), .dwritedata(dwritedata[0]),
    .dbyteenable(dbyteenable[0]), .dread(dread[0]), .dreaddata(dreaddata0),
    .dwaitrequest(dwaitrequest0), .err_clr(err_clr[0]), .bus_error(bus_error0)
  );

  rv32i_mem_responder #(.MEM_LOG2_WORDS(12), .BASE_ADDR(32'h0), .RD_WAIT_STATES(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .iaddress(iaddress[1]), .iread(iread[1]), .ireaddata(ireaddata1),
    .daddress(daddress[1]), .dwrite(dwrite[1]), .dwritedata(dwritedata[1]),
    .dbyteenable(dbyteenable[1]), .dread(dread[1]), .dreaddata(dreaddata1),
    .dwaitrequest(dwaitrequest1), .err_clr(err_clr[1]), .bus_error(bus_error1)
  );

  function automatic logic [31:0] rd_data(input int u);
    return (u == 0) ? dreaddata0 : dreaddata1;
  endfunction

  function automatic logic wait_req(input int u);
    return (u == 0) ? dwaitrequest0 : dwaitrequest1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int u, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    daddress[u] = a; dwritedata[u] = d; dbyteenable[u] = be; dwrite[u] = 1'b1;
    step();
    dwrite[u] = 1'b0;
  endtask

  task automatic do_iread(input string tag, input logic [31:0] a, input logic [31:0] exp);
    iaddress[0] = a; iread[0] = 1'b1;
    step();
    iread[0] = 1'b0;
    chk(tag, ireaddata0, exp);
  endtask

  // Counts cycles from the current one until dwaitrequest is seen low; 64 means it never dropped.
  task automatic wait_done(input int u, output int c);
    c = 0;
    while (c < 64) begin
      @(negedge clk);
      if (!wait_req(u)) break;
      c++;
    end
  endtask

  task automatic do_read(input string tag, input int u, input logic [31:0] a,
                         input logic [31:0] exp, input int lat);
    int c;
    sb.push_back(exp);
    daddress[u] = a; dread[u] = 1'b1;
    wait_done(u, c);
    chk({tag, "_lat"}, 32'(c), 32'(lat));
    chk({tag, "_data"}, rd_data(u), sb.pop_front());
    step();
    dread[u] = 1'b0;
  endtask

  initial begin
    int c;
    reset_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      iaddress[u] = '0; daddress[u] = '0; dwritedata[u] = '0; dbyteenable[u] = '0;
      iread[u] = 1'b0; dwrite[u] = 1'b0; dread[u] = 1'b0; err_clr[u] = 1'b0;
    end
    #12;
    chk("rst_wreq", dwaitrequest0, 32'h0);
    chk("rst_rdata", dreaddata0, 32'h0);
    chk("rst_idata", ireaddata0, 32'h0);
    chk("rst_err", bus_error0, 32'h0);
    step();
    reset_n = 1'b1;
    step();

    do_write(0, 32'h100, 32'hDEADBEEF, 4'hF);
    do_read("rd_100", 0, 32'h100, 32'hDEADBEEF, 3);
    chk("err_after_rd", bus_error0, 32'h0);

    do_write(0, 32'h20, 32'h11223344, 4'hF);
    do_write(0, 32'h20, 32'hAABBCCDD, 4'b0101);
    do_read("rd_lanes", 0, 32'h20, 32'h11BB33DD, 3);
    do_read("rd_lowbits", 0, 32'h102, 32'hDEADBEEF, 3);

    do_write(0, 32'h40, 32'h7, 4'hF);
    iaddress[0] = 32'h40; iread[0] = 1'b1;
    daddress[0] = 32'h40; dwritedata[0] = 32'h5; dbyteenable[0] = 4'hF; dwrite[0] = 1'b1;
    step();
    iread[0] = 1'b0; dwrite[0] = 1'b0;
    chk("rbw_old", ireaddata0, 32'h7);
    do_iread("rbw_new", 32'h40, 32'h5);
    step();
    chk("ihold", ireaddata0, 32'h5);

    do_read("rd_oor", 0, 32'h4000, 32'h0, 3);
    chk("oor_rd_err", bus_error0, 32'h1);
    err_clr[0] = 1'b1; step(); err_clr[0] = 1'b0;
    chk("err_clr", bus_error0, 32'h0);

    do_iread("ird_oor_nop", 32'h4000, 32'h13);
    chk("oor_ird_err", bus_error0, 32'h1);
    err_clr[0] = 1'b1; step(); err_clr[0] = 1'b0;

    do_write(0, 32'h0, 32'hCAFEF00D, 4'hF);
    chk("wr_ok_noerr", bus_error0, 32'h0);
    do_write(0, 32'h4000, 32'h12345678, 4'hF);
    chk("oor_wr_err", bus_error0, 32'h1);
    do_read("oor_wr_keep", 0, 32'h0, 32'hCAFEF00D, 3);
    err_clr[0] = 1'b1; step(); err_clr[0] = 1'b0;

    sb.push_back(32'hDEADBEEF);
    daddress[0] = 32'h100; dread[0] = 1'b1;
    dwritedata[0] = 32'h0; dbyteenable[0] = 4'hF; dwrite[0] = 1'b1;
    step();
    dwrite[0] = 1'b0;
    wait_done(0, c);
    chk("rdwr_lat", 32'(c), 32'h2);
    chk("rdwr_data", dreaddata0, sb.pop_front());
    step(); dread[0] = 1'b0;
    chk("rdwr_err", bus_error0, 32'h1);
    do_read("rdwr_keep", 0, 32'h100, 32'hDEADBEEF, 3);
    err_clr[0] = 1'b1; step(); err_clr[0] = 1'b0;

    daddress[0] = 32'h100; dread[0] = 1'b1;
    step();
    dread[0] = 1'b0;
    @(negedge clk);
    chk("abort_wait", dwaitrequest0, 32'h1);
    step();
    chk("abort_idle", dwaitrequest0, 32'h0);
    chk("abort_nodata", dreaddata0, 32'h0);
    step();
    chk("abort_nodata2", dreaddata0, 32'h0);

    err_clr[0] = 1'b1;
    do_write(0, 32'h4000, 32'h1, 4'hF);
    err_clr[0] = 1'b0;
    chk("clr_vs_set", bus_error0, 32'h1);

    daddress[0] = 32'h100; dread[0] = 1'b1;
    step();
    @(negedge clk);
    chk("prerst_wreq", dwaitrequest0, 32'h1);
    reset_n = 1'b0; dread[0] = 1'b0;
    #1;
    chk("rst_async_wreq", dwaitrequest0, 32'h0);
    chk("rst_async_idata", ireaddata0, 32'h0);
    chk("rst_async_err", bus_error0, 32'h0);
    step(); step();
    reset_n = 1'b1;
    step();
    do_read("post_rst", 0, 32'h100, 32'hDEADBEEF, 3);

    do_write(1, 32'h0, 32'h01010101, 4'hF);
    do_write(1, 32'h4, 32'h02020202, 4'hF);
    sb.push_back(32'h01010101);
    sb.push_back(32'h02020202);
    daddress[1] = 32'h0; dread[1] = 1'b1;
    wait_done(1, c);
    chk("b2b_lat0", 32'(c), 32'h2);
    chk("b2b_data0", dreaddata1, sb.pop_front());
    step();
    daddress[1] = 32'h4;
    wait_done(1, c);
    chk("b2b_lat1", 32'(c), 32'h2);
    chk("b2b_data1", dreaddata1, sb.pop_front());
    step();
    dread[1] = 1'b0;
    chk("b2b_err", bus_error1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
